// File: rtl/stream_pkg.sv
// Shared definitions for the stream FIFO slice.
//   level_width(depth) : width of a counter that can hold 0..depth+1
//   ptr_width(depth)   : width of an array pointer for a power-of-two depth
package stream_pkg;

  // Occupancy spans 0..DEPTH+1 (array plus output register).
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 2);
  endfunction

  // Array pointers wrap naturally because depth is a power of two.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Array count spans 0..depth.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stream_ram.sv
// Simple dual-port register-array memory: synchronous write, combinational read.
// No reset on the storage; validity is tracked by the owner's count.
// Ports:
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
module stream_ram
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage write.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stream_fifo_buffer.sv
// AXI-Stream style FIFO: DEPTH-entry array followed by a registered output
// stage, giving DEPTH+1 beats of capacity with full throughput. up_tready and
// all downstream outputs are registered; flush clears contents synchronously.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : synchronous clear, priority over transfers
//   up_tdata/tlast/tvalid, up_tready : upstream stream (ready registered)
//   dn_tdata/tlast/tvalid, dn_tready : downstream stream (outputs registered)
//   level             : beats held (array + output register)
//   almost_full       : level >= ALMOST_FULL
module stream_fifo_buffer
  import stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ALMOST_FULL = DEPTH,
  localparam int unsigned LW         = level_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] up_tdata,
  input  logic                  up_tlast,
  input  logic                  up_tvalid,
  output logic                  up_tready,
  output logic [DATA_WIDTH-1:0] dn_tdata,
  output logic                  dn_tlast,
  output logic                  dn_tvalid,
  input  logic                  dn_tready,
  output logic [LW-1:0]         level,
  output logic                  almost_full
);

  localparam int unsigned BW  = DATA_WIDTH + 1;
  localparam int unsigned PW  = ptr_width(DEPTH);
  localparam int unsigned CW  = count_width(DEPTH);
  localparam int unsigned CAP = DEPTH + 1;

  // Registered state
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [LW-1:0]         r_level;
  logic                  r_up_tready;
  logic                  r_almost_full;
  logic                  r_dn_tvalid;
  logic                  r_dn_tlast;
  logic [DATA_WIDTH-1:0] r_dn_tdata;

  // Combinational control
  logic                  w_push;
  logic                  w_pop;
  logic                  w_out_free;
  logic                  w_arr_empty;
  logic                  w_load_head;
  logic                  w_bypass;
  logic                  w_wr;
  logic [LW-1:0]         w_level_next;
  logic [CW-1:0]         w_count_next;
  logic [BW-1:0]         w_wr_beat;
  logic [BW-1:0]         w_rd_beat;

  assign w_push      = up_tvalid & r_up_tready;
  assign w_pop       = r_dn_tvalid & dn_tready;
  assign w_out_free  = ~r_dn_tvalid | dn_tready;
  assign w_arr_empty = (r_count == CW'(0));
  // Output stage refills from the array head first; bypass only when the array is empty.
  assign w_load_head = w_out_free & ~w_arr_empty;
  assign w_bypass    = w_out_free & w_arr_empty & w_push;
  assign w_wr        = w_push & ~w_bypass & ~flush;
  assign w_wr_beat   = {up_tlast, up_tdata};

  // Next occupancy of the whole buffer and of the array alone.
  always_comb begin
    w_level_next = r_level;
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LW'(1);
      2'b01:   w_level_next = r_level - LW'(1);
      default: w_level_next = r_level;
    endcase
    case ({w_wr, w_load_head})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  stream_ram #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_beat),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_beat)
  );

  // Control, pointers, output valid/last and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_level       <= '0;
      r_up_tready   <= 1'b0;
      r_almost_full <= 1'b0;
      r_dn_tvalid   <= 1'b0;
      r_dn_tlast    <= 1'b0;
    end else if (flush) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_level       <= '0;
      r_up_tready   <= 1'b1;
      r_almost_full <= 1'b0;
      r_dn_tvalid   <= 1'b0;
      r_dn_tlast    <= 1'b0;
    end else begin
      r_count       <= w_count_next;
      r_level       <= w_level_next;
      r_up_tready   <= (w_level_next != LW'(CAP));
      r_almost_full <= (w_level_next >= LW'(ALMOST_FULL));
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_load_head) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_out_free) begin
        r_dn_tvalid <= w_load_head | w_bypass;
        if (w_load_head) begin
          r_dn_tlast <= w_rd_beat[DATA_WIDTH];
        end else if (w_bypass) begin
          r_dn_tlast <= up_tlast;
        end
      end
    end
  end

  // Output data carries no reset; it is qualified by dn_tvalid.
  always_ff @(posedge clk) begin
    if (w_load_head) begin
      r_dn_tdata <= w_rd_beat[DATA_WIDTH-1:0];
    end else if (w_bypass) begin
      r_dn_tdata <= up_tdata;
    end
  end

  assign up_tready   = r_up_tready;
  assign dn_tdata    = r_dn_tdata;
  assign dn_tlast    = r_dn_tlast;
  assign dn_tvalid   = r_dn_tvalid;
  assign level       = r_level;
  assign almost_full = r_almost_full;

endmodule

// File: tb/tb_stream_fifo_buffer.sv
// Randomised and directed bench for stream_fifo_buffer against a queue model.
module tb_stream_fifo_buffer;

  localparam int unsigned DW  = 32;
  localparam int unsigned DEP = 4;
  localparam int unsigned AF  = 4;
  localparam int unsigned CAP = DEP + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [DW-1:0] up_tdata;
  logic          up_tlast;
  logic          up_tvalid;
  logic          up_tready;
  logic [DW-1:0] dn_tdata;
  logic          dn_tlast;
  logic          dn_tvalid;
  logic          dn_tready;
  logic [2:0]    level;
  logic          almost_full;

  stream_fifo_buffer #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEP),
    .ALMOST_FULL (AF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .up_tdata    (up_tdata),
    .up_tlast    (up_tlast),
    .up_tvalid   (up_tvalid),
    .up_tready   (up_tready),
    .dn_tdata    (dn_tdata),
    .dn_tlast    (dn_tlast),
    .dn_tvalid   (dn_tvalid),
    .dn_tready   (dn_tready),
    .level       (level),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  // Reference model: the buffer is an ordered queue of {last,data} beats.
  logic [DW:0] m_q[$];
  bit          m_ready;
  bit          m_push;
  bit          m_pop;
  int          n_checks;
  int          n_pass;
  int          n_pops;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_clear_reset();
    m_q.delete();
    m_ready = 1'b0;
    m_push  = 1'b0;
    m_pop   = 1'b0;
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit push;
    bit pop;
    if (rst) begin
      model_clear_reset();
      return;
    end
    push = up_tvalid && m_ready;
    pop  = (m_q.size() > 0) && dn_tready;
    if (flush) begin
      m_q.delete();
      m_ready = 1'b1;
      m_push  = 1'b0;
      m_pop   = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back({up_tlast, up_tdata});
      m_ready = (m_q.size() != CAP);
      m_push  = push;
      m_pop   = pop;
      if (pop) n_pops++;
    end
  endtask

  task automatic check_outputs();
    check("level", 64'(level), 64'(m_q.size()));
    check("dn_tvalid", 64'(dn_tvalid), 64'(m_q.size() > 0));
    check("up_tready", 64'(up_tready), 64'(m_ready));
    check("almost_full", 64'(almost_full), 64'(m_q.size() >= AF));
    if (m_q.size() > 0) check("dn_beat", 64'({dn_tlast, dn_tdata}), 64'(m_q[0]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int idx;
    int cyc;
    logic [DW:0] pend;
    n_checks = 0;
    n_pass   = 0;
    n_pops   = 0;
    rst = 1'b1; flush = 1'b0;
    up_tdata = '0; up_tlast = 1'b0; up_tvalid = 1'b0; dn_tready = 1'b0;
    model_clear_reset();

    // Reset state and first beat latency
    repeat (2) step();
    rst = 1'b0;
    #1 check_outputs();
    up_tvalid = 1'b1; up_tdata = 32'hA0; dn_tready = 1'b1;
    step();
    check("rel_ready", 64'(up_tready), 64'd1);
    check("rel_level", 64'(level), 64'd0);
    step();
    check("first_level", 64'(level), 64'd1);
    check("first_data", 64'(dn_tdata), 64'hA0);
    up_tvalid = 1'b0;
    step();
    check("first_drain", 64'(level), 64'd0);
    step();

    // Fill to capacity while stalled
    dn_tready = 1'b0;
    idx = 1;
    for (int c = 0; c < 12 && idx <= 6; c++) begin
      up_tvalid = 1'b1; up_tdata = DW'(idx); up_tlast = 1'b0;
      step();
      if (m_push) idx++;
    end
    check("fill_level", 64'(level), 64'd5);
    check("fill_ready", 64'(up_tready), 64'd0);
    check("fill_head", 64'(dn_tdata), 64'd1);
    check("fill_af", 64'(almost_full), 64'd1);
    // One pop frees a slot; 0x6 then enters
    dn_tready = 1'b1;
    step();
    dn_tready = 1'b0;
    step();
    check("refill_level", 64'(level), 64'd5);
    up_tvalid = 1'b0; dn_tready = 1'b1;
    repeat (7) step();

    // Streaming at full rate, tlast every 4th beat
    for (int i = 0; i < 20; i++) begin
      up_tvalid = 1'b1; up_tdata = DW'(32'h100 + i); up_tlast = ((i % 4) == 3);
      dn_tready = 1'b1;
      step();
      check("stream_level", 64'(level), 64'd1);
    end
    up_tvalid = 1'b0;
    repeat (2) step();

    // Randomised handshakes
    n_pops = 0;
    cyc = 0;
    pend = {1'($urandom_range(0, 1)), DW'($urandom)};
    up_tvalid = 1'b0;
    while (n_pops < 1000 && cyc < 20000) begin
      if (!up_tvalid) up_tvalid = ($urandom_range(0, 1) == 1);
      {up_tlast, up_tdata} = pend;
      dn_tready = ($urandom_range(0, 1) == 1);
      step();
      cyc++;
      if (m_push) begin
        pend = {1'($urandom_range(0, 1)), DW'($urandom)};
        up_tvalid = ($urandom_range(0, 1) == 1);
      end
    end
    check("random_budget", 64'(n_pops >= 1000), 64'd1);
    up_tvalid = 1'b0; dn_tready = 1'b1;
    repeat (6) step();

    // Flush at level 3 with concurrent push and pop
    dn_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      up_tvalid = 1'b1; up_tdata = DW'(32'h200 + i); up_tlast = 1'b0;
      step();
    end
    check("preflush_level", 64'(level), 64'd3);
    flush = 1'b1; up_tvalid = 1'b1; up_tdata = 32'h2FF; dn_tready = 1'b1;
    step();
    flush = 1'b0; up_tvalid = 1'b0;
    check("flush_level", 64'(level), 64'd0);
    check("flush_valid", 64'(dn_tvalid), 64'd0);
    check("flush_ready", 64'(up_tready), 64'd1);
    repeat (4) step();

    // Asynchronous reset mid-stream
    dn_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      up_tvalid = 1'b1; up_tdata = DW'(32'h300 + i); up_tlast = (i == 2);
      step();
    end
    #2 rst = 1'b1;
    model_clear_reset();
    #1 check_outputs();
    check("arst_level", 64'(level), 64'd0);
    repeat (2) step();
    rst = 1'b0; dn_tready = 1'b1;
    #1 check_outputs();
    step();
    check("arst_rel_ready", 64'(up_tready), 64'd1);
    up_tvalid = 1'b0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_fifo_buffer.md
Name: stream_fifo_buffer

Overview:
- Parametrised successor to the single-entry skid stage: AXI-Stream-style FIFO with configurable width and depth, registered up_tready, registered downstream outputs, occupancy/almost-full status and synchronous flush.
- Sits between stream producers and consumers where more than one beat of elasticity is needed, such as absorbing consumer stalls or decoupling bursty producers.
- Full throughput of one beat per cycle in steady state. Beat order and tlast framing are preserved exactly.

Parameters:
- DATA_WIDTH, 32, width of tdata.
- DEPTH, 4, number of storage-array entries; power of two, at least 2. Total capacity CAP = DEPTH+1, i.e. the array plus the output register.
- ALMOST_FULL, DEPTH, level at or above which almost_full asserts; range 1..CAP.
- LW (localparam), $clog2(DEPTH+2), width of level.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of all contents.
- up_tdata  in  DATA_WIDTH  upstream data.
- up_tlast  in  1  upstream end-of-packet.
- up_tvalid  in  1  upstream valid.
- up_tready  out  1  upstream ready; registered.
- dn_tdata  out  DATA_WIDTH  downstream data; registered.
- dn_tlast  out  1  downstream end-of-packet; registered.
- dn_tvalid  out  1  downstream valid; registered.
- dn_tready  in  1  downstream ready.
- level  out  LW  beats held, counting array plus output register; registered, range 0..CAP.
- almost_full  out  1  registered; equals (level >= ALMOST_FULL).

Behaviour:
- Reset, asynchronous: up_tready=0, dn_tvalid=0, dn_tlast=0, level=0, almost_full=0, read/write pointers=0. dn_tdata and the array contents are not reset.
- First rising edge after reset release: up_tready=1. No beat is accepted on that edge, because up_tready was 0 when it was sampled.
- Transfer definitions: push = up_tvalid & up_tready; pop = dn_tvalid & dn_tready.
- out_free = ~dn_tvalid | dn_tready.
- level_next = level + push - pop.
- Registered status: up_tready <= (level_next != CAP); almost_full <= (level_next >= ALMOST_FULL).
- Output register load, when out_free:
  - Array non-empty: load the array head, advance the read pointer, dn_tvalid<=1.
  - Array empty and push: bypass the incoming beat directly into the output register, dn_tvalid<=1.
  - Otherwise: dn_tvalid<=0.
- While ~out_free, the output register holds. dn_tdata, dn_tlast and dn_tvalid are stable while stalled (AXI rule).
- Array write happens on a push that is not bypassed. That covers the array being non-empty, or the output register being occupied and not popping. Data and last are stored together and the write pointer advances.
- Latency: when empty, a pushed beat is visible on dn_* the cycle after acceptance. Otherwise it is visible after all older beats.
- Pointer arithmetic: pointers are $clog2(DEPTH) bits and wrap naturally. Array empty/full is tracked by an internal count, not by pointer compare.
- Full (level==CAP):
  - up_tready is 0. If a pop occurs, up_tready returns to 1 on the next edge.
  - An offered beat is never dropped, and no beat is accepted while up_tready=0.
- Simultaneous push and pop at level 1 with an empty array: the bypass loads the new beat in the same edge, level stays 1, and there is no bubble.
- Simultaneous push and pop with a non-empty array: the head moves to the output register, the incoming beat is written to the array, and level is unchanged.
- Flush, sampled on an edge, with priority over all transfers:
  - Pointers and count cleared, dn_tvalid<=0, dn_tlast<=0, level<=0, almost_full<=0, up_tready<=1.
  - Any push or pop in the flush cycle is discarded.
- Reset mid-operation: all contents are lost immediately when rst asserts, with no partial-beat output.

Decomposition:
- Shared package stream_pkg: a function computing the level width from DEPTH, and a packed struct beat_t {tlast, tdata} if the package is made parametric via a typedef in the module. Otherwise the beat is a {last,data} concatenation of DATA_WIDTH+1 bits.
- One sub-module, stream_ram:
  - Register-array simple-dual-port memory, DEPTH x (DATA_WIDTH+1).
  - Synchronous write, combinational read, no reset.
- Control, pointers, bypass mux and status stay in stream_fifo_buffer.

Test Plan (DEPTH=4, CAP=5, ALMOST_FULL=4, DATA_WIDTH=32):
- Reset release, then up_tvalid=1 with data 0xA0 and dn_tready=1 -> up_tready=1 one edge after release; 0xA0 accepted on the next edge; dn_tvalid=1 with dn_tdata=0xA0 the following cycle; level 1 then 0; there are no duplicates.
- Hold dn_tready=0 and push 0x1..0x6 continuously -> exactly 5 beats accepted; level=5; up_tready=0 after the 5th; almost_full=1 after the 4th; dn_tdata stays 0x1 throughout the stall.
- From the full state, assert dn_tready=1 for one cycle -> 0x1 popped; level=4; up_tready=1 next edge; 0x6 accepted afterwards; drain order is 0x2,0x3,0x4,0x5,0x6.
- Streaming with up_tvalid=1 and dn_tready=1 for 20 cycles, tlast on every 4th beat -> one beat per cycle; level stays 1; dn_tlast is aligned with the 4th, 8th and later beats.
- Randomised up_tvalid/dn_tready at 50% for 1000 beats -> output sequence equals input sequence; no beat lost or duplicated; dn_* stable while dn_tvalid=1 and dn_tready=0.
- With level=3, assert flush together with up_tvalid=1 and dn_tready=1 -> next cycle level=0, dn_tvalid=0, up_tready=1, and no beat from before the flush appears later; asserting rst mid-stream gives the same result asynchronously, with up_tready=0 until the first edge after release.
